// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer (BOOT -> RUN, REDIR bubble after a redirect).
// Define FETCH_CTRL_BUF_EN to insert a 2-entry FIFO between icache and decode.
module fetch_ctrl #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            icache_stall_i,
  input  logic [31:0]     icache_instr_i,
  output logic            pc_v_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            branch_v_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic            flush_v_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            dec_ready_i,
  output logic            dec_valid_o,
  output logic [31:0]     dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, REDIR = 2'd2} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_ent_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redir_tgt;
  logic            redir;
  logic            accept;

  // Redirects are meaningless before the first fetch, so BOOT masks them.
  assign redir     = (flush_v_i | branch_v_i) & (state_q != BOOT);
  assign redir_tgt = (flush_v_i ? flush_pc_i : branch_pc_i) & ~XLEN'(3);
  assign pc_o      = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = redir ? REDIR : RUN;
      REDIR:   state_d = redir ? REDIR : RUN;
      default: state_d = BOOT;
    endcase
  end

`ifdef FETCH_CTRL_BUF_EN
  fetch_ent_t head_q, tail_q, new_ent;
  logic [1:0] cnt_q;
  logic       pop, room;

  assign new_ent.pc    = pc_q;
  assign new_ent.instr = icache_instr_i;

  always_comb begin
    pop         = (cnt_q != 2'd0) & dec_ready_i;
    room        = (cnt_q != 2'd2) | pop;
    pc_v_o      = (state_q == RUN) & room;
    accept      = pc_v_o & ~icache_stall_i & ~redir;
    dec_valid_o = (cnt_q != 2'd0);
    dec_instr_o = head_q.instr;
    dec_pc_o    = head_q.pc;
  end

  // head_q is always the oldest entry, so decode sees a registered head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else if (redir) begin
      cnt_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= new_ent;
          else               tail_q <= new_ent;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) head_q <= new_ent;
          else begin
            head_q <= tail_q;
            tail_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt_q <= 2'd2);
`else
  // Pass-through: the icache word goes straight to decode, so decode backpressure stalls the PC.
  always_comb begin
    pc_v_o      = (state_q == RUN);
    dec_valid_o = pc_v_o & ~icache_stall_i & ~redir;
    accept      = dec_valid_o & dec_ready_i;
    dec_instr_o = pc_v_o ? icache_instr_i : '0;
    dec_pc_o    = pc_v_o ? pc_q : '0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pc_q <= RESET_VECTOR;
    else if (redir)  pc_q <= redir_tgt;
    else if (accept) pc_q <= pc_q + XLEN'(4);
  end

  a_boot_idle:  assert property (@(posedge clk) disable iff (reset)
                  (state_q == BOOT) |-> (!pc_v_o && !dec_valid_o));
  a_redir_idle: assert property (@(posedge clk) disable iff (reset)
                  (state_q == REDIR) |-> (!pc_v_o && !dec_valid_o));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed boundary cases then random traffic against a queue-based model.
module tb_fetch_ctrl;
  localparam logic [31:0] RV = 32'h0000_0100;
`ifdef FETCH_CTRL_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam int LAT = BUF ? 1 : 0;

  logic        clk = 1'b0, reset = 1'b0;
  logic        icache_stall_i = 1'b0, branch_v_i = 1'b0, flush_v_i = 1'b0, dec_ready_i = 1'b1;
  logic [31:0] icache_instr_i, branch_pc_i = '0, flush_pc_i = '0;
  logic        pc_v_o, dec_valid_o;
  logic [31:0] pc_o, dec_instr_o, dec_pc_o;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset),
    .icache_stall_i(icache_stall_i), .icache_instr_i(icache_instr_i),
    .pc_v_o(pc_v_o), .pc_o(pc_o),
    .branch_v_i(branch_v_i), .branch_pc_i(branch_pc_i),
    .flush_v_i(flush_v_i), .flush_pc_i(flush_pc_i),
    .dec_ready_i(dec_ready_i), .dec_valid_o(dec_valid_o),
    .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] h(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // The icache returns a word derived from the address it was asked for.
  assign icache_instr_i = h(pc_o);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 boot, 1 run, 2 bubble; m_q holds fetched-but-undelivered addresses.
  int          m_st;
  logic [31:0] m_pc;
  logic [31:0] m_q[$];

  function automatic bit m_redir();
    return (flush_v_i || branch_v_i) && (m_st != 0);
  endfunction
  function automatic bit m_pop();
    return BUF && (m_q.size() != 0) && dec_ready_i;
  endfunction
  function automatic bit m_pcv();
    return (m_st == 1) && (!BUF || m_q.size() < 2 || m_pop());
  endfunction
  function automatic bit m_dv();
    if (BUF) return m_q.size() != 0;
    return (m_st == 1) && !icache_stall_i && !m_redir();
  endfunction
  function automatic logic [31:0] m_dpc();
    if (!BUF) return m_pc;
    return (m_q.size() != 0) ? m_q[0] : 32'h0;
  endfunction
  function automatic bit m_accept();
    if (BUF) return m_pcv() && !icache_stall_i && !m_redir();
    return m_dv() && dec_ready_i;
  endfunction

  initial begin
    bit rd, acc, pp;
    m_st = 0;
    m_pc = RV;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_st = 0;
        m_pc = RV;
        m_q.delete();
      end else begin
        rd  = m_redir();
        pp  = m_pop();
        acc = m_accept();
        if (rd) begin
          m_q.delete();
          m_pc = (flush_v_i ? flush_pc_i : branch_pc_i) & ~32'h3;
        end else begin
          if (pp) void'(m_q.pop_front());
          if (acc) begin
            if (BUF) m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
          end
        end
        m_st = (m_st == 0) ? 1 : (rd ? 2 : 1);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk1("rst_pc_v", pc_v_o, 1'b0);
      chk ("rst_pc", pc_o, RV);
      chk1("rst_dec_valid", dec_valid_o, 1'b0);
      chk ("rst_dec_pc", dec_pc_o, 32'h0);
      chk ("rst_dec_instr", dec_instr_o, 32'h0);
    end else begin
      chk1("pc_v", pc_v_o, m_pcv());
      chk ("pc", pc_o, m_pc);
      chk1("dec_valid", dec_valid_o, m_dv());
      if (m_dv()) begin
        chk("dec_pc", dec_pc_o, m_dpc());
        chk("dec_instr", dec_instr_o, h(m_dpc()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk ("lit_rst_pc", pc_o, 32'h100);
    chk ("lit_rst_dpc", dec_pc_o, 32'h0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk1("lit_boot_pcv", pc_v_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      if (i < 3) chk("lit_seq_pc", pc_o, 32'(32'h100 + 4 * i));
      if (i >= LAT && i - LAT < 3) chk("lit_seq_dpc", dec_pc_o, 32'(32'h100 + 4 * (i - LAT)));
    end

    // Stall window at 0x104 after a fresh reset.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk1("lit_pulse_dv", dec_valid_o, 1'b0);
    chk ("lit_pulse_pc", pc_o, RV);
    step();
    reset = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("lit_pre_stall_pc", pc_o, 32'h100);
    step();
    icache_stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk ("lit_stall_pc", pc_o, 32'h104);
      chk1("lit_stall_dv", dec_valid_o, BUF && k == 0);
      if (k < 2) step();
    end
    step();
    icache_stall_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk1("lit_unstall_dv", dec_valid_o, j >= LAT);
      if (j >= LAT) chk("lit_unstall_dpc", dec_pc_o, 32'(32'h104 + 4 * (j - LAT)));
      step();
    end

    // Simultaneous branch and flush: flush wins.
    branch_v_i = 1'b1; branch_pc_i = 32'h2002;
    flush_v_i  = 1'b1; flush_pc_i  = 32'h8000;
    @(negedge clk);
    chk1("lit_redir_dv", dec_valid_o, BUF);
    step();
    branch_v_i = 1'b0; flush_v_i = 1'b0;
    @(negedge clk);
    chk1("lit_bubble_pcv", pc_v_o, 1'b0);
    chk1("lit_bubble_dv", dec_valid_o, 1'b0);
    step();
    @(negedge clk);
    chk ("lit_tgt_pc", pc_o, 32'h8000);
    chk1("lit_tgt_dv", dec_valid_o, !BUF);
    step();
    @(negedge clk);
    chk("lit_tgt_dpc", dec_pc_o, BUF ? 32'h8000 : 32'h8004);

    // Wrap-around at the top of the address space; low target bits are dropped.
    step();
    branch_v_i = 1'b1; branch_pc_i = 32'hFFFF_FFFE;
    step();
    branch_v_i = 1'b0;
    @(negedge clk);
    chk("lit_wrap_tgt", pc_o, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    chk1("lit_wrap_pcv", pc_v_o, 1'b1);
    step();
    @(negedge clk);
    chk("lit_wrap_pc", pc_o, 32'h0);

    // Decode backpressure for 5 cycles, then drain.
    step();
    dec_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    chk1("lit_bp_pcv", pc_v_o, !BUF);
    chk ("lit_bp_pc", pc_o, BUF ? 32'h8 : 32'h4);
    chk ("lit_bp_dpc", dec_pc_o, BUF ? 32'h0 : 32'h4);
    step();
    dec_ready_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("lit_drain_dpc", dec_pc_o, 32'((BUF ? 0 : 4) + 4 * j));
      step();
    end

    // Reset with the path backed up, then boot again.
    dec_ready_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk1("lit_midrst_dv", dec_valid_o, 1'b0);
    chk ("lit_midrst_pc", pc_o, RV);
    step();
    reset = 1'b0;
    dec_ready_i = 1'b1;
    @(negedge clk);
    chk1("lit_reboot_pcv", pc_v_o, 1'b0);
    step();
    @(negedge clk);
    chk("lit_reboot_pc0", pc_o, 32'h100);
    step();
    @(negedge clk);
    chk("lit_reboot_pc1", pc_o, 32'h104);

    // Random traffic; the compare process checks every cycle.
    for (int n = 0; n < 800; n++) begin
      step();
      icache_stall_i = ($urandom % 4) == 0;
      dec_ready_i    = ($urandom % 4) != 0;
      branch_v_i     = ($urandom % 16) == 0;
      flush_v_i      = ($urandom % 32) == 0;
      branch_pc_i    = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      flush_pc_i     = $urandom;
      if (n == 400) reset = 1'b1;
      if (n == 403) reset = 1'b0;
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 32: PC/address width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 icache_stall_i  in  1  icache cannot return data this cycle.
REQ-006 icache_instr_i  in  32  instruction for pc_o, valid when pc_v_o & ~icache_stall_i.
REQ-007 pc_v_o  out  1  fetch request valid (drives fetch line0 PC valid).
REQ-008 pc_o  out  XLEN  fetch address (drives fetch line0 PC).
REQ-009 branch_v_i / branch_pc_i  in  1 / XLEN  branch redirect from execute.
REQ-010 flush_v_i / flush_pc_i  in  1 / XLEN  trap/flush redirect from commit.
REQ-011 dec_ready_i  in  1  decode accepts an instruction this cycle.
REQ-012 dec_valid_o / dec_instr_o / dec_pc_o  out  1 / 32 / XLEN  instruction to decode.

Function
REQ-013 FSM states BOOT, RUN, REDIR; one-hot or binary encoding is implementation choice.
REQ-014 BOOT: pc_v_o=0, dec_valid_o=0; unconditional transition to RUN on next edge.
REQ-015 RUN: pc_v_o=1 unless fetch path full (REQ-021/REQ-024).
REQ-016 Fetch accepted in a cycle when pc_v_o=1, icache_stall_i=0, and the fetch path can absorb it; PC register then updates to pc_o+4, modulo 2^XLEN (wraps to 0).
REQ-017 icache_stall_i=1: PC register holds; no instruction captured; no state change other than redirects.
REQ-018 Redirect: flush_v_i has priority over branch_v_i; on either in RUN, PC register loads target with bits [1:0] forced to 0, FSM goes to REDIR, any instruction returned that cycle is discarded.
REQ-019 REDIR: pc_v_o=0, dec_valid_o=0 for exactly one cycle, then RUN; a redirect arriving in REDIR reloads PC and stays in REDIR one further cycle.
REQ-020 Redirects in BOOT are ignored.
REQ-021 Decode handshake: instruction transfers when dec_valid_o & dec_ready_i; dec_instr_o/dec_pc_o stable while dec_valid_o=1 and dec_ready_i=0.
REQ-022 dec_pc_o equals the address the instruction was fetched from.

Reset
REQ-023 While reset=1: state=BOOT, PC register=RESET_VECTOR, pc_v_o=0, pc_o=RESET_VECTOR, dec_valid_o=0, dec_instr_o=0, dec_pc_o=0, buffer empty; reset asserted mid-operation discards all in-flight instructions immediately.

Configuration
REQ-024 Macro FETCH_CTRL_BUF_EN defined: 2-entry FIFO between icache and decode; fetch accepted when FIFO not full or an entry is popped the same cycle; dec_* driven registered from FIFO head; redirect empties FIFO same edge; first instruction reaches dec_valid_o one cycle after acceptance.
REQ-025 FETCH_CTRL_BUF_EN undefined: no storage; dec_valid_o = RUN & ~icache_stall_i; dec_instr_o=icache_instr_i, dec_pc_o=pc_o combinationally; fetch accepted only when dec_ready_i=1, else PC holds; a redirect in the same cycle forces dec_valid_o=0.

Verification
REQ-026 Reset release, RESET_VECTOR=0x100, no stalls, dec_ready_i=1 -> BOOT one cycle, then pc_o 0x100,0x104,0x108 on consecutive cycles; dec_pc_o follows same sequence.
REQ-027 icache_stall_i=1 for 3 cycles at pc_o=0x104 -> pc_o held at 0x104, dec_valid_o=0 for those cycles, then 0x104 delivered once, no duplicate or skip.
REQ-028 branch_v_i=1, branch_pc_i=0x2002 with flush_v_i=1, flush_pc_i=0x8000 same cycle -> one bubble cycle, next pc_o=0x8000; instruction fetched in redirect cycle never reaches decode.
REQ-029 With FETCH_CTRL_BUF_EN, dec_ready_i=0 for 5 cycles -> exactly 2 instructions buffered, pc_v_o=0 thereafter, PC holds; on dec_ready_i=1 both drain in order, then fetch resumes.
REQ-030 PC at 0xFFFF_FFFC (XLEN=32) accepted -> next pc_o=0x0000_0000.
REQ-031 reset pulsed mid-stream with 2 buffered entries -> dec_valid_o=0 immediately, pc_o=RESET_VECTOR, boot sequence of REQ-026 repeats.
